branch_resolve_update: RTL and testbench
========================================

Name: branch_resolve_update

Overview:
- Decode-stage counterpart of the fetch-side branch predictor (BTB + 2-bit BHT).
- Carries each fetched instruction's prediction metadata from F into D and compares it with the real outcome resolved in D.
- On mismatch, raises the flush and redirect to fetch.
- Queues BTB/BHT write-back commands: allocate, counter update, invalidate. The predictor drains them through a valid/ready port.

Parameters:
IDX_W, 5, BTB index width; index = pc[IDX_W+1:2]
QDEPTH, 4, update FIFO depth (power of two, >=2)
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
pcF  in  32  PC of instruction in F
predHitF  in  1  BTB hit for pcF
predTakenF  in  1  predictor says taken
predTargetF  in  32  predicted target
predCtrF  in  2  BHT counter read for pcF
stallD  in  1  hazard unit holds D
flushD  in  1  external flush of D (e.g. jump)
branchD  in  1  instruction in D is beq/bne
takenD  in  1  resolved branch condition
targetD  in  32  resolved branch target
mispredict  out  1  kill F instruction this cycle
redirect_pc  out  32  correct next fetch PC, valid with mispredict
upd_valid  out  1  update command available
upd_ready  in  1  predictor accepts command
upd_op  out  2  01 counter update, 10 allocate, 11 invalidate
upd_idx  out  IDX_W  BTB index
upd_pc  out  32  branch PC (tag)
upd_target  out  32  target to write
upd_ctr  out  2  new counter value
br_cnt  out  CNT_W  resolved branches
mp_cnt  out  CNT_W  mispredictions
drop_cnt  out  CNT_W  updates lost to full FIFO

Behaviour:
- Reset (rst_n=0 at edge): validD=0, D metadata=0, FIFO empty, all counters 0. Outputs all 0 during and after reset until first event. Takes priority over every other event, including a mid-transfer upd_valid.
- D register update, per edge:
  - flushD | mispredict: validD<=0 (flush beats stall).
  - else if !stallD: load pcF/pred*F, validD<=1.
  - else hold.
- Resolve: res = validD & !stallD. Each D instruction resolves exactly once; no action while stalled.
- Address arithmetic is 32-bit, wrap-around ignored. pc4 = pcD+4.
  - Predicted next PC: pnext = predTakenD ? predTargetD : pc4.
  - Actual next PC: anext = takenD ? targetD : pc4.
- Branch (res & branchD):
  - br_cnt++.
  - mispredict = (pnext != anext), combinational in the same cycle; redirect_pc = anext.
  - mp_cnt++ on mispredict.
- Alias (res & !branchD & predHitD & predTakenD): mispredict=1, redirect_pc=pc4, mp_cnt++. Enqueue invalidate (op 11, ctr 00, target 0).
- Update generation for branches:
  - Hit: enqueue op 01, ctr = saturating predCtrD+1 if taken else -1 (11 stays 11, 00 stays 00). Target = targetD if taken else predTargetD.
  - Miss and taken: enqueue op 10, ctr 10, target targetD.
  - Miss and not taken: no enqueue.
- redirect_pc = 0 when mispredict=0.
- FIFO:
  - upd_* driven from head; upd_valid = !empty.
  - Pop on upd_valid & upd_ready.
  - Push when not full, or when full with a pop in the same cycle.
  - Full with no pop: command dropped, drop_cnt++.
  - Simultaneous push/pop on empty: the push is not visible until the next cycle; no bypass.
  - Head fields stable while upd_valid & !upd_ready.
- All statistics counters saturate at all-ones.

Test Plan:
- Reset: rst_n=0 for 2 cycles with pcF toggling -> validD=0, upd_valid=0, mispredict=0, counters 0.
- Cold miss, taken: pcF=0x10, predHitF=0, branchD=1, takenD=1, targetD=0x20 -> mispredict=1, redirect_pc=0x20. One cycle later upd_valid=1, op 10, idx 4, ctr 10, target 0x20. validD=0 on the next cycle.
- Hit, correct: pcF=0x20, hit, predTaken=1, ctr 11, target 0x2C, takenD=1 -> mispredict=0, op 01, ctr 11 (saturate), br_cnt+1, mp_cnt unchanged.
- Hit, wrong: pcF=0x10, hit, taken, ctr 10, takenD=0 -> mispredict=1, redirect_pc=0x14, op 01, ctr 01.
- Stall then flush: stallD=1 for 3 cycles with a branch in D -> no resolve, no enqueue. flushD with stallD=1 -> validD=0 next cycle.
- Back-pressure: upd_ready=0, 5 distinct updates with QDEPTH=4 -> 4 queued in order, drop_cnt=1, head stable. Raise upd_ready -> 4 pops on consecutive cycles, then upd_valid=0.

Source files
------------

// File: rtl/branch_resolve_update.sv
// Decode-side branch resolution: compares F-stage prediction metadata
// with the D-stage outcome, redirects fetch and queues predictor updates.
module branch_resolve_update #(
  parameter int IDX_W  = 5,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pcF,
  input  logic             predHitF,
  input  logic             predTakenF,
  input  logic [31:0]      predTargetF,
  input  logic [1:0]       predCtrF,
  input  logic             stallD,
  input  logic             flushD,
  input  logic             branchD,
  input  logic             takenD,
  input  logic [31:0]      targetD,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [1:0]       upd_op,
  output logic [IDX_W-1:0] upd_idx,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic [1:0]       upd_ctr,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mp_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int AW = $clog2(QDEPTH);
  localparam int EW = 2 + IDX_W + 32 + 32 + 2;
  localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

  logic             r_validD;
  logic [31:0]      r_pcD;
  logic             r_hitD;
  logic             r_takD;
  logic [31:0]      r_tgtD;
  logic [1:0]       r_ctrD;

  logic [EW-1:0]    r_mem [QDEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [CNT_W-1:0] r_br;
  logic [CNT_W-1:0] r_mp;
  logic [CNT_W-1:0] r_drop;

  logic          w_res;
  logic          w_br;
  logic          w_alias;
  logic [31:0]   w_pc4;
  logic [31:0]   w_pnext;
  logic [31:0]   w_anext;
  logic          w_bmis;
  logic          w_req;
  logic [1:0]    w_op;
  logic [1:0]    w_ctr;
  logic [1:0]    w_ctr_hit;
  logic [31:0]   w_tgt;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_res   = r_validD & ~stallD;
  assign w_br    = w_res & branchD;
  assign w_alias = w_res & ~branchD & r_hitD & r_takD;
  assign w_pc4   = r_pcD + 32'd4;
  assign w_pnext = r_takD ? r_tgtD : w_pc4;
  assign w_anext = takenD ? targetD : w_pc4;
  assign w_bmis  = w_br & (w_pnext != w_anext);

  assign mispredict  = w_bmis | w_alias;
  assign redirect_pc = w_alias ? w_pc4 :
                       w_bmis  ? w_anext : 32'd0;

  assign w_ctr_hit = takenD ?
    ((r_ctrD == 2'b11) ? 2'b11 : r_ctrD + 2'd1) :
    ((r_ctrD == 2'b00) ? 2'b00 : r_ctrD - 2'd1);

  // Build the update command for the instruction resolving now
  always_comb begin
    w_req = 1'b0;
    w_op  = 2'b00;
    w_ctr = 2'b00;
    w_tgt = 32'd0;
    unique case (1'b1)
      w_alias: begin
        w_req = 1'b1;
        w_op  = 2'b11;
      end
      w_br & r_hitD: begin
        w_req = 1'b1;
        w_op  = 2'b01;
        w_ctr = w_ctr_hit;
        w_tgt = takenD ? targetD : r_tgtD;
      end
      w_br & ~r_hitD & takenD: begin
        w_req = 1'b1;
        w_op  = 2'b10;
        w_ctr = 2'b10;
        w_tgt = targetD;
      end
      default: ;
    endcase
  end

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = ~w_empty & upd_ready;
  assign w_push  = w_req & (~w_full | w_pop);
  assign w_drop  = w_req & w_full & ~w_pop;

  assign w_head = r_mem[r_rd[AW-1:0]];
  assign upd_valid = ~w_empty;
  assign {upd_op, upd_idx, upd_pc, upd_target, upd_ctr} =
    w_empty ? '0 : w_head;

  assign br_cnt   = r_br;
  assign mp_cnt   = r_mp;
  assign drop_cnt = r_drop;

  // D-stage metadata register: flush beats stall, stall holds
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_validD <= 1'b0;
      r_pcD    <= '0;
      r_hitD   <= 1'b0;
      r_takD   <= 1'b0;
      r_tgtD   <= '0;
      r_ctrD   <= '0;
    end else if (flushD | mispredict) begin
      r_validD <= 1'b0;
    end else if (!stallD) begin
      r_validD <= 1'b1;
      r_pcD    <= pcF;
      r_hitD   <= predHitF;
      r_takD   <= predTakenF;
      r_tgtD   <= predTargetF;
      r_ctrD   <= predCtrF;
    end
  end

  // Update FIFO storage, written at the tail
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr[AW-1:0]] <=
        {w_op, r_pcD[IDX_W+1:2], r_pcD, w_tgt, w_ctr};
  end

  // FIFO pointers and saturating statistics
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_br   <= '0;
      r_mp   <= '0;
      r_drop <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_br && r_br != CMAX) r_br <= r_br + 1'b1;
      if (mispredict && r_mp != CMAX) r_mp <= r_mp + 1'b1;
      if (w_drop && r_drop != CMAX) r_drop <= r_drop + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolve_update.sv
// Bench for branch_resolve_update: directed plan plus random traffic
// checked every cycle against a behavioural model.
module tb_branch_resolve_update;

  localparam int IDX_W = 5;
  localparam int QD    = 4;

  logic clk = 0;
  logic rst_n;
  logic [31:0] pcF, predTargetF, targetD;
  logic predHitF, predTakenF, stallD, flushD, branchD, takenD;
  logic [1:0] predCtrF;
  logic upd_ready;
  logic mispredict, upd_valid;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [1:0] upd_op, upd_ctr;
  logic [IDX_W-1:0] upd_idx;
  logic [15:0] br_cnt, mp_cnt, drop_cnt;

  always #5 clk = ~clk;

  branch_resolve_update #(.IDX_W(IDX_W), .QDEPTH(QD), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .pcF(pcF), .predHitF(predHitF),
    .predTakenF(predTakenF), .predTargetF(predTargetF),
    .predCtrF(predCtrF), .stallD(stallD), .flushD(flushD),
    .branchD(branchD), .takenD(takenD), .targetD(targetD),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_op(upd_op),
    .upd_idx(upd_idx), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_ctr(upd_ctr), .br_cnt(br_cnt), .mp_cnt(mp_cnt),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [1:0]  ctr;
  } cmd_t;

  // model state
  bit          m_v;
  logic [31:0] m_pc, m_tgt;
  bit          m_hit, m_tak;
  int          m_ctr;
  cmd_t        m_q[$];
  int          m_br, m_mp, m_drop;
  bit          m_known;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat16(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  // compare DUT against model, then advance model across the next edge
  task automatic cyc();
    bit res, misp, have;
    logic [31:0] pc4, pn, an, rd;
    cmd_t c;
    #1;
    res  = m_v && !stallD;
    pc4  = m_pc + 32'd4;
    pn   = m_tak ? m_tgt : pc4;
    an   = takenD ? targetD : pc4;
    misp = 0;
    rd   = 0;
    have = 0;
    c.op = 0; c.pc = m_pc; c.tgt = 0; c.ctr = 0;
    if (res && branchD) begin
      if (pn != an) begin misp = 1; rd = an; end
      if (m_hit) begin
        have  = 1;
        c.op  = 2'b01;
        c.ctr = 2'(takenD ? ((m_ctr == 3) ? 3 : m_ctr + 1)
                          : ((m_ctr == 0) ? 0 : m_ctr - 1));
        c.tgt = takenD ? targetD : m_tgt;
      end else if (takenD) begin
        have = 1; c.op = 2'b10; c.ctr = 2'b10; c.tgt = targetD;
      end
    end else if (res && m_hit && m_tak) begin
      misp = 1; rd = pc4; have = 1; c.op = 2'b11;
    end
    if (m_known) begin
      chk("mispredict", 32'(mispredict), 32'(misp));
      chk("redirect_pc", redirect_pc, rd);
      chk("upd_valid", 32'(upd_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("upd_op", 32'(upd_op), 32'(m_q[0].op));
        chk("upd_idx", 32'(upd_idx), 32'(m_q[0].pc[IDX_W+1:2]));
        chk("upd_pc", upd_pc, m_q[0].pc);
        chk("upd_target", upd_target, m_q[0].tgt);
        chk("upd_ctr", 32'(upd_ctr), 32'(m_q[0].ctr));
      end
      chk("br_cnt", 32'(br_cnt), 32'(m_br));
      chk("mp_cnt", 32'(mp_cnt), 32'(m_mp));
      chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    end
    if (!rst_n) begin
      m_v = 0; m_pc = 0; m_tgt = 0; m_hit = 0; m_tak = 0; m_ctr = 0;
      m_q.delete(); m_br = 0; m_mp = 0; m_drop = 0; m_known = 1;
    end else begin
      if (res && branchD) m_br = sat16(m_br);
      if (misp) m_mp = sat16(m_mp);
      if (upd_ready && m_q.size() > 0) void'(m_q.pop_front());
      if (have) begin
        if (m_q.size() < QD) m_q.push_back(c);
        else m_drop = sat16(m_drop);
      end
      if (flushD || misp) m_v = 0;
      else if (!stallD) begin
        m_v = 1; m_pc = pcF; m_hit = predHitF; m_tak = predTakenF;
        m_tgt = predTargetF; m_ctr = int'(predCtrF);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic setF(logic [31:0] pc, bit h, bit t,
                      logic [31:0] tg, logic [1:0] ct);
    pcF = pc; predHitF = h; predTakenF = t;
    predTargetF = tg; predCtrF = ct;
  endtask

  task automatic setD(bit b, bit t, logic [31:0] tg);
    branchD = b; takenD = t; targetD = tg;
  endtask

  initial begin
    m_known = 0;
    rst_n = 0; stallD = 0; flushD = 0; upd_ready = 1;
    setF(0, 0, 0, 0, 0);
    setD(0, 0, 0);
    @(negedge clk);
    // reset with toggling pcF
    for (int i = 0; i < 2; i++) begin
      pcF = 32'h100 * (i + 1);
      cyc();
    end
    #1;
    chk("rst_upd_valid", 32'(upd_valid), 0);
    chk("rst_br_cnt", 32'(br_cnt), 0);
    rst_n = 1;

    // cold miss taken
    setF(32'h10, 0, 0, 0, 0);
    cyc();
    setD(1, 1, 32'h20);
    setF(32'h20, 1, 1, 32'h2C, 3);
    #1;
    chk("cold_misp", 32'(mispredict), 1);
    chk("cold_redir", redirect_pc, 32'h20);
    cyc();
    setD(0, 0, 0);
    #1;
    chk("cold_uv", 32'(upd_valid), 1);
    chk("cold_op", 32'(upd_op), 2);
    chk("cold_idx", 32'(upd_idx), 4);
    chk("cold_ctr", 32'(upd_ctr), 2);
    chk("cold_tgt", upd_target, 32'h20);
    cyc();
    // hit, correct
    setD(1, 1, 32'h2C);
    setF(32'h10, 1, 1, 32'h20, 2);
    #1;
    chk("hitok_misp", 32'(mispredict), 0);
    cyc();
    // hit, wrong
    setD(1, 0, 32'h20);
    #1;
    chk("hitok_op", 32'(upd_op), 1);
    chk("hitok_ctr", 32'(upd_ctr), 3);
    chk("hitok_br", 32'(br_cnt), 2);
    chk("hitok_mp", 32'(mp_cnt), 1);
    chk("hitbad_misp", 32'(mispredict), 1);
    chk("hitbad_redir", redirect_pc, 32'h14);
    cyc();
    setD(0, 0, 0);
    setF(32'h40, 0, 0, 0, 0);
    #1;
    chk("hitbad_op", 32'(upd_op), 1);
    chk("hitbad_ctr", 32'(upd_ctr), 1);
    chk("hitbad_tgt", upd_target, 32'h20);
    cyc();
    // stall with branch in D
    stallD = 1;
    setD(1, 1, 32'h80);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_misp", 32'(mispredict), 0);
      cyc();
    end
    chk("stall_br", 32'(br_cnt), 3);
    flushD = 1;
    cyc();
    stallD = 0; flushD = 0;
    setF(32'h0, 0, 0, 0, 0);
    #1;
    chk("flush_misp", 32'(mispredict), 0);
    cyc();
    chk("flush_br", 32'(br_cnt), 3);
    chk("flush_uv", 32'(upd_valid), 0);
    // back-pressure: 5 correct not-taken hit updates
    upd_ready = 0;
    for (int k = 0; k < 6; k++) begin
      setF(32'h100 + 32'(4 * k), 1, 0, 32'h200 + 32'(k), 2'(k));
      setD(k > 0, 0, 0);
      cyc();
    end
    setD(0, 0, 0);
    setF(32'h0, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("bp_drop", 32'(drop_cnt), 1);
    chk("bp_head", upd_pc, 32'h100);
    upd_ready = 1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("bp_pop_pc", upd_pc, 32'h100 + 32'(4 * j));
      cyc();
    end
    chk("bp_empty", 32'(upd_valid), 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      stallD = ($urandom_range(0, 4) == 0);
      flushD = ($urandom_range(0, 9) == 0);
      upd_ready = ($urandom_range(0, 2) != 0);
      setF({24'h0, 6'($urandom), 2'b00}, 1'($urandom),
           1'($urandom), {24'h0, 6'($urandom), 2'b00},
           2'($urandom));
      setD(($urandom_range(0, 3) != 0), 1'($urandom),
           {24'h0, 6'($urandom), 2'b00});
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
